// File: rtl/dcache_store_responder_pkg.sv
// Shared types and helpers for the D$ store-port responder.
// Provides the request/response structs of the store_buffer <-> D$ port,
// the responder FSM state type and the address decode helpers used by both
// the request path and the debug read-back path.
package dcache_store_responder_pkg;

    localparam int unsigned XLEN               = 32'd64;
    localparam int unsigned PLEN               = 32'd56;
    localparam int unsigned DCACHE_INDEX_WIDTH = 32'd12;
    localparam int unsigned DCACHE_TAG_WIDTH   = PLEN - DCACHE_INDEX_WIDTH;
    localparam int unsigned BE_W               = XLEN / 32'd8;
    localparam int unsigned WORD_SHIFT         = $clog2(XLEN / 32'd8);

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [XLEN-1:0]               data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [BE_W-1:0]               data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic            data_gnt;
        logic            data_rvalid;
        logic [XLEN-1:0] data_rdata;
    } dcache_req_o_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } resp_state_e;

    // Word offset of paddr relative to base (meaningful only when in range).
    function automatic logic [PLEN-1:0] addr_word(input logic [PLEN-1:0] paddr,
                                                  input logic [PLEN-1:0] base);
        return (paddr - base) >> WORD_SHIFT;
    endfunction

    // True when paddr falls inside a memory of 'words' words starting at base.
    // The >= test matters: below base the subtraction wraps to a huge offset.
    function automatic logic addr_in_range(input logic [PLEN-1:0] paddr,
                                           input logic [PLEN-1:0] base,
                                           input logic [PLEN-1:0] words);
        return (paddr >= base) && (addr_word(paddr, base) < words);
    endfunction

endpackage

// File: rtl/dcache_store_responder_store_resp_mem.sv
// Backing memory of the store responder.
// Ports:
//   clk, rst_n           clock, async active-low reset (clears every word)
//   wr_en/wr_idx/wr_be/wr_data   byte-enabled write port
//   rd_en/rd_hit/rd_idx  capture port: on rd_en, rd_data takes mem[rd_idx]
//                        (pre-write value) or 0 when rd_hit is low
//   rd_data              registered capture result, held between captures
//   dbg_idx/dbg_hit      combinational read-back address and range flag
//   dbg_data             mem[dbg_idx], or 0 when dbg_hit is low
module store_resp_mem
    import dcache_store_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32'd64,
    parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [BE_W-1:0]  wr_be,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             rd_en,
    input  logic             rd_hit,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [XLEN-1:0]  rd_data,
    input  logic [IDX_W-1:0] dbg_idx,
    input  logic             dbg_hit,
    output logic [XLEN-1:0]  dbg_data
);

    logic [XLEN-1:0] mem_r [MEM_WORDS];
    logic [XLEN-1:0] rd_data_r;

    // Memory array: async clear, byte-lane merge on write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (wr_be[b]) begin
                    mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Load capture: samples the array before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {XLEN{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= rd_hit ? mem_r[rd_idx] : {XLEN{1'b0}};
        end
    end

    assign rd_data = rd_data_r;

    // Combinational debug read-back.
    always_comb begin
        dbg_data = {XLEN{1'b0}};
        if (dbg_hit) begin
            dbg_data = mem_r[dbg_idx];
        end else begin
            dbg_data = {XLEN{1'b0}};
        end
    end

endmodule

// File: rtl/dcache_store_responder.sv
// D$-side responder for the store_buffer store port.
// Grants requests after GNT_LATENCY cycles, merges byte-enabled stores into a
// small backing memory, answers loads one cycle after grant and exposes the
// memory through a combinational debug port.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   req_port_i      request (index, tag, wdata, req, we, be, size, kill_req)
//   req_port_o      data_gnt (combinational), data_rvalid, data_rdata
//   dbg_addr_i      physical address for read-back
//   dbg_rdata_o     word holding dbg_addr_i, 0 when out of range
//   store_cnt_o     committed in-range stores, wrapping
//   err_o           sticky out-of-range access flag
module dcache_store_responder
    import dcache_store_responder_pkg::*;
#(
    parameter int unsigned      GNT_LATENCY = 32'd2,
    parameter int unsigned      MEM_WORDS   = 32'd64,
    parameter logic [PLEN-1:0]  BASE_ADDR   = 56'h00_0000_8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  dcache_req_i_t   req_port_i,
    output dcache_req_o_t   req_port_o,
    input  logic [PLEN-1:0] dbg_addr_i,
    output logic [XLEN-1:0] dbg_rdata_o,
    output logic [31:0]     store_cnt_o,
    output logic            err_o
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    // A zero-latency responder never waits, but keep a 1-bit counter so
    // every width stays legal.
    localparam int unsigned CNT_W = (GNT_LATENCY > 32'd0) ? $clog2(GNT_LATENCY + 32'd1) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((GNT_LATENCY > 32'd0) ? (GNT_LATENCY - 32'd1) : 32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    resp_state_e      state_r, state_n_s;
    logic [CNT_W-1:0] cnt_r, cnt_n_s;
    logic             gnt_s;
    logic             live_req_s;
    logic [PLEN-1:0]  paddr_s;
    logic [PLEN-1:0]  req_word_s;
    logic [PLEN-1:0]  dbg_word_s;
    logic             req_hit_s;
    logic             dbg_hit_s;
    logic             accept_s;
    logic             store_commit_s;
    logic             load_accept_s;
    logic             oob_s;
    logic             rvalid_r;
    logic [31:0]      store_cnt_r;
    logic             err_r;
    logic [XLEN-1:0]  rdata_s;
    logic             unused_s;

    assign paddr_s    = {req_port_i.address_tag, req_port_i.address_index};
    assign req_word_s = addr_word(paddr_s, BASE_ADDR);
    assign dbg_word_s = addr_word(dbg_addr_i, BASE_ADDR);
    assign req_hit_s  = addr_in_range(paddr_s, BASE_ADDR, PLEN'(MEM_WORDS));
    assign dbg_hit_s  = addr_in_range(dbg_addr_i, BASE_ADDR, PLEN'(MEM_WORDS));
    assign live_req_s = req_port_i.data_req & ~req_port_i.kill_req;

    // Size is ignored (byte enables alone pick lanes); tag is taken as valid.
    assign unused_s = ^{req_word_s[PLEN-1:IDX_W], dbg_word_s[PLEN-1:IDX_W],
                        req_port_i.data_size, req_port_i.tag_valid};

    // Grant FSM: next state, latency counter and the combinational grant.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        gnt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!live_req_s) begin
                    state_n_s = ST_IDLE;
                end else if (GNT_LATENCY == 32'd0) begin
                    gnt_s = 1'b1;
                end else begin
                    cnt_n_s   = CNT_LOAD;
                    state_n_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!live_req_s) begin
                    // Request withdrawn or killed: abandon without access.
                    state_n_s = ST_IDLE;
                end else if (cnt_r == CNT_ZERO) begin
                    gnt_s     = 1'b1;
                    state_n_s = ST_IDLE;
                end else begin
                    cnt_n_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    assign accept_s       = req_port_i.data_req & gnt_s;
    assign store_commit_s = accept_s & req_port_i.data_we & req_hit_s;
    assign load_accept_s  = accept_s & ~req_port_i.data_we;
    assign oob_s          = accept_s & ~req_hit_s;

    // FSM state and latency counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Load-valid pulse, store counter and sticky range error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r    <= 1'b0;
            store_cnt_r <= 32'd0;
            err_r       <= 1'b0;
        end else begin
            rvalid_r <= load_accept_s;
            if (store_commit_s) begin
                store_cnt_r <= store_cnt_r + 32'd1;
            end
            if (oob_s) begin
                err_r <= 1'b1;
            end
        end
    end

    store_resp_mem #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .wr_en    (store_commit_s),
        .wr_idx   (req_word_s[IDX_W-1:0]),
        .wr_be    (req_port_i.data_be),
        .wr_data  (req_port_i.data_wdata),
        .rd_en    (load_accept_s),
        .rd_hit   (req_hit_s),
        .rd_idx   (req_word_s[IDX_W-1:0]),
        .rd_data  (rdata_s),
        .dbg_idx  (dbg_word_s[IDX_W-1:0]),
        .dbg_hit  (dbg_hit_s),
        .dbg_data (dbg_rdata_o)
    );

    // Response port assembly.
    always_comb begin
        req_port_o.data_gnt    = gnt_s;
        req_port_o.data_rvalid = rvalid_r;
        req_port_o.data_rdata  = rdata_s;
    end

    assign store_cnt_o = store_cnt_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_dcache_store_responder.sv
// Self-checking bench for dcache_store_responder. Two instances share the
// clock: index 0 has zero grant latency, index 1 has a latency of two.
module tb_dcache_store_responder;
    import dcache_store_responder_pkg::*;

    localparam int MW = 64;
    localparam logic [PLEN-1:0] BASE = 56'h00_0000_8000_0000;

    logic            clk = 1'b0;
    logic            rst_ni;
    dcache_req_i_t   req0, req1;
    dcache_req_o_t   rsp0, rsp1;
    logic [PLEN-1:0] dbg_addr;
    logic [63:0]     dbg0, dbg1;
    logic [31:0]     cnt0, cnt1;
    logic            err0, err1;

    always #5 clk = ~clk;

    dcache_store_responder #(.GNT_LATENCY(0), .MEM_WORDS(MW), .BASE_ADDR(BASE)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .req_port_i(req0), .req_port_o(rsp0),
        .dbg_addr_i(dbg_addr), .dbg_rdata_o(dbg0), .store_cnt_o(cnt0), .err_o(err0));

    dcache_store_responder #(.GNT_LATENCY(2), .MEM_WORDS(MW), .BASE_ADDR(BASE)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .req_port_i(req1), .req_port_o(rsp1),
        .dbg_addr_i(dbg_addr), .dbg_rdata_o(dbg1), .store_cnt_o(cnt1), .err_o(err1));

    // Reference model: one memory image, counter and error flag per instance.
    logic [63:0] ref_mem [2][MW];
    int unsigned ref_cnt [2];
    bit          ref_err [2];
    logic [63:0] exp_q0 [$];
    logic [63:0] exp_q1 [$];

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat(int s);
        return (s == 0) ? 0 : 2;
    endfunction

    function automatic bit in_rng(logic [PLEN-1:0] a);
        return (a >= BASE) && (((a - BASE) / 8) < MW);
    endfunction

    function automatic logic get_gnt(int s);
        return (s == 0) ? rsp0.data_gnt : rsp1.data_gnt;
    endfunction

    task automatic set_req(int s, dcache_req_i_t r);
        if (s == 0) req0 = r;
        else        req1 = r;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < MW; i++) ref_mem[s][i] = 64'd0;
            ref_cnt[s] = 0;
            ref_err[s] = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Effect of one accepted access on the model.
    task automatic model_access(int s, logic [PLEN-1:0] a, bit we, logic [7:0] be, logic [63:0] wd);
        int w;
        logic [63:0] rd;
        w  = int'((a - BASE) / 8);
        rd = 64'd0;
        if (!in_rng(a)) ref_err[s] = 1'b1;
        else            rd = ref_mem[s][w];
        if (!we) begin
            if (s == 0) exp_q0.push_back(rd);
            else        exp_q1.push_back(rd);
        end else if (in_rng(a)) begin
            for (int b = 0; b < 8; b++)
                if (be[b]) ref_mem[s][w][8*b +: 8] = wd[8*b +: 8];
            ref_cnt[s] = ref_cnt[s] + 1;
        end
    endtask

    // Present a request, wait (bounded) for the grant, check its latency.
    // Returns on the falling edge of the grant cycle; req stays asserted.
    task automatic access(int s, logic [PLEN-1:0] a, bit we, logic [7:0] be, logic [63:0] wd);
        dcache_req_i_t r;
        int n;
        bit g;
        r               = '0;
        r.address_index = a[DCACHE_INDEX_WIDTH-1:0];
        r.address_tag   = a[PLEN-1:DCACHE_INDEX_WIDTH];
        r.data_wdata    = wd;
        r.data_req      = 1'b1;
        r.data_we       = we;
        r.data_be       = be;
        r.data_size     = 2'd3;
        r.tag_valid     = 1'b1;
        @(posedge clk); #1;
        set_req(s, r);
        n = 0;
        g = 1'b0;
        while (!g && n < 20) begin
            @(negedge clk);
            if (get_gnt(s)) g = 1'b1;
            else            n++;
        end
        check("gnt_latency", 64'(n), 64'(lat(s)));
        if (g) model_access(s, a, we, be, wd);
    endtask

    task automatic idle(int s);
        @(posedge clk); #1;
        set_req(s, '0);
    endtask

    task automatic check_state(string tag);
        for (int i = 0; i < MW; i++) begin
            dbg_addr = BASE + PLEN'(i * 8 + int'($urandom_range(0, 7)));
            #1;
            check({tag, "_dbg0"}, dbg0, ref_mem[0][i]);
            check({tag, "_dbg1"}, dbg1, ref_mem[1][i]);
        end
        dbg_addr = BASE + PLEN'(MW * 8);
        #1;
        check({tag, "_dbg_hi0"}, dbg0, 64'd0);
        check({tag, "_dbg_hi1"}, dbg1, 64'd0);
        dbg_addr = BASE - 56'd8;
        #1;
        check({tag, "_dbg_lo0"}, dbg0, 64'd0);
        check({tag, "_dbg_lo1"}, dbg1, 64'd0);
        check({tag, "_cnt0"}, 64'(cnt0), 64'(ref_cnt[0]));
        check({tag, "_cnt1"}, 64'(cnt1), 64'(ref_cnt[1]));
        check({tag, "_err0"}, 64'(err0), 64'(ref_err[0]));
        check({tag, "_err1"}, 64'(err1), 64'(ref_err[1]));
    endtask

    // Monitor: every load response is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (rsp0.data_rvalid) begin
                if (exp_q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rvalid0_unexpected: got rvalid=1 expected rvalid=0");
                end else begin
                    check("load_data0", rsp0.data_rdata, exp_q0.pop_front());
                end
            end
            if (rsp1.data_rvalid) begin
                if (exp_q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rvalid1_unexpected: got rvalid=1 expected rvalid=0");
                end else begin
                    check("load_data1", rsp1.data_rdata, exp_q1.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        dcache_req_i_t kr;
        logic [PLEN-1:0] a;
        int s, len;
        req0     = '0;
        req1     = '0;
        dbg_addr = BASE;
        rst_ni   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_gnt0", 64'(rsp0.data_gnt), 64'd0);
        check("rst_gnt1", 64'(rsp1.data_gnt), 64'd0);
        check("rst_rdata1", rsp1.data_rdata, 64'd0);
        check_state("rst");

        // Full store with latency 2.
        access(1, BASE + 56'd8, 1'b1, 8'hFF, 64'hDEAD_BEEF_0123_4567);
        idle(1);
        @(negedge clk);
        dbg_addr = BASE + 56'd8;
        #1;
        check("full_store", dbg1, 64'hDEAD_BEEF_0123_4567);
        check("full_store_cnt", 64'(cnt1), 64'd1);

        // Partial store onto the same word.
        access(1, BASE + 56'd8, 1'b1, 8'h0F, 64'd0);
        idle(1);
        @(negedge clk);
        #1;
        check("partial_store", dbg1, 64'hDEAD_BEEF_0000_0000);

        // Kill while waiting: no grant, nothing written.
        kr               = '0;
        kr.address_index = 12'd8;
        kr.address_tag   = BASE[PLEN-1:DCACHE_INDEX_WIDTH];
        kr.data_wdata    = 64'hFFFF_FFFF_FFFF_FFFF;
        kr.data_req      = 1'b1;
        kr.data_we       = 1'b1;
        kr.data_be       = 8'hFF;
        @(posedge clk); #1;
        set_req(1, kr);
        @(negedge clk);
        check("kill_gnt_a", 64'(rsp1.data_gnt), 64'd0);
        @(posedge clk); #1;
        kr.kill_req = 1'b1;
        set_req(1, kr);
        repeat (2) begin
            @(negedge clk);
            check("kill_gnt_b", 64'(rsp1.data_gnt), 64'd0);
            @(posedge clk); #1;
        end
        set_req(1, '0);
        @(negedge clk);
        dbg_addr = BASE + 56'd8;
        #1;
        check("kill_word", dbg1, ref_mem[1][1]);
        check("kill_cnt", 64'(cnt1), 64'(ref_cnt[1]));
        // FSM must be back in IDLE: the next request sees the full latency.
        access(1, BASE + 56'd8, 1'b0, 8'hFF, 64'd0);
        idle(1);

        // Zero latency back-to-back stores, then a load.
        for (int k = 0; k < 4; k++)
            access(0, BASE + PLEN'(8 * k), 1'b1, 8'hFF, {$urandom, $urandom});
        idle(0);
        @(negedge clk);
        check("b2b_cnt", 64'(cnt0), 64'd4);
        access(0, BASE + 56'd16, 1'b0, 8'hFF, 64'd0);
        idle(0);
        repeat (2) @(negedge clk);

        // Out of range store: granted, error next cycle, sticky, no count.
        access(0, BASE + PLEN'(8 * MW), 1'b1, 8'hFF, {$urandom, $urandom});
        idle(0);
        @(negedge clk);
        check("oob_err", 64'(err0), 64'd1);
        check("oob_cnt", 64'(cnt0), 64'd4);
        repeat (3) @(negedge clk);
        check_state("oob");

        // Randomized bursts on a randomly chosen instance.
        for (int burst = 0; burst < 60; burst++) begin
            s   = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 5));
            for (int k = 0; k < len; k++) begin
                case ($urandom_range(0, 9))
                    0:       a = BASE + PLEN'(8 * MW) + PLEN'($urandom_range(0, 64));
                    1:       a = BASE - PLEN'($urandom_range(1, 64));
                    default: a = BASE + PLEN'($urandom_range(0, 8 * MW - 1));
                endcase
                access(s, a, $urandom_range(0, 3) != 0, 8'($urandom), {$urandom, $urandom});
            end
            idle(s);
        end
        repeat (3) @(negedge clk);
        check_state("rand");
        check("pending0", 64'(exp_q0.size()), 64'd0);
        check("pending1", 64'(exp_q1.size()), 64'd0);

        // Reset in the middle of a wait: everything back to reset values.
        kr.kill_req      = 1'b0;
        kr.address_index = 12'd16;
        @(posedge clk); #1;
        set_req(1, kr);
        @(posedge clk); #1;
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_mid_gnt", 64'(rsp1.data_gnt), 64'd0);
        @(posedge clk); #1;
        set_req(1, '0);
        rst_ni = 1'b1;
        @(negedge clk);
        check("rst_mid_rvalid0", 64'(rsp0.data_rvalid), 64'd0);
        check("rst_mid_rvalid1", 64'(rsp1.data_rvalid), 64'd0);
        check("rst_mid_rdata0", rsp0.data_rdata, 64'd0);
        check("rst_mid_rdata1", rsp1.data_rdata, 64'd0);
        check_state("rst_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
